// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: access sizes,
// FSM states, bus widths and the alignment rule used by DATA_MEM_ALIGN_CHECK_EN.
package data_mem_ctrl_pkg;

  localparam int MemAddrW = 32;
  localparam int MemDataW = 32;
  localparam int MemWenW  = MemDataW / 8;

  localparam logic [1:0] MemByte = 2'b00;
  localparam logic [1:0] MemHalf = 2'b01;
  localparam logic [1:0] MemWord = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } state_e;

  // Reserved size 11 behaves like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MemByte: is_misaligned = 1'b0;
      MemHalf: is_misaligned = addr_lo[0];
      default: is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_lane.sv
// mem_lane_align: byte-enable generation, store-data replication and
// load shift/extension for one access. Purely combinational.
module mem_lane_align
  import data_mem_ctrl_pkg::*;
(
  input  logic                is_store,
  input  logic [1:0]          size,
  input  logic                sign,
  input  logic [1:0]          addr_lo,
  input  logic [MemDataW-1:0] wdata,
  input  logic [MemDataW-1:0] rdata,
  output logic [MemWenW-1:0]  wen,
  output logic [MemDataW-1:0] wdata_rep,
  output logic [MemDataW-1:0] rdata_ext
);

  logic [MemDataW-1:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    wen       = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = shifted;
    case (size)
      MemByte: begin
        wen       = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign & shifted[7]}}, shifted[7:0]};
      end
      MemHalf: begin
        wen       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{sign & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        wen       = 4'b1111;
        rdata_ext = rdata;
      end
    endcase
    if (!is_store) begin
      wen = 4'b0000;
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory access controller: IDLE/WAIT/RESP handshake with the data SRAM.
// Define DATA_MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses with addr_err.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_sign,
  input  logic [MemAddrW-1:0] req_addr,
  input  logic [MemDataW-1:0] req_wdata,
  output logic                stallreq,
  output logic                resp_valid,
  output logic [MemDataW-1:0] resp_rdata,
  output logic                bus_err,
  output logic                addr_err,
  output logic [MemAddrW-1:0] badvaddr,
  output logic                data_sram_en,
  output logic [MemWenW-1:0]  data_sram_wen,
  output logic [MemAddrW-1:0] data_sram_addr,
  output logic [MemDataW-1:0] data_sram_wdata,
  input  logic [MemDataW-1:0] data_sram_rdata,
  input  logic                data_sram_ready
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                sign_q, sign_d;
  logic [MemAddrW-1:0] addr_q, addr_d;
  logic [MemDataW-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MemDataW-1:0] rdata_q, rdata_d;
  logic                bus_err_q, bus_err_d;
  logic                addr_err_q, addr_err_d;
  logic [MemAddrW-1:0] badvaddr_q, badvaddr_d;

  logic [MemWenW-1:0]  lane_wen;
  logic [MemDataW-1:0] lane_wdata;
  logic [MemDataW-1:0] lane_rdata;
  logic                in_wait;

  mem_lane_align u_lane (
    .is_store  (we_q),
    .size      (size_q),
    .sign      (sign_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata     (data_sram_rdata),
    .wen       (lane_wen),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      sign_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      bus_err_q  <= 1'b0;
      addr_err_q <= 1'b0;
      badvaddr_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      bus_err_q  <= bus_err_d;
      addr_err_q <= addr_err_d;
      badvaddr_q <= badvaddr_d;
    end
  end

  // Response registers default to 0 so they are only non-zero during RESP.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    sign_d     = sign_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rdata_d    = '0;
    bus_err_d  = 1'b0;
    addr_err_d = 1'b0;
    badvaddr_d = '0;
    stallreq   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          stallreq = 1'b1;
          we_d     = req_we;
          size_d   = req_size;
          sign_d   = req_sign;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          cnt_d    = '0;
          state_d  = S_WAIT;
`ifdef DATA_MEM_ALIGN_CHECK_EN
          if (is_misaligned(req_size, req_addr[1:0])) begin
            addr_err_d = 1'b1;
            badvaddr_d = req_addr;
            state_d    = S_RESP;
          end
`endif
        end
      end
      S_WAIT: begin
        stallreq = 1'b1;
        // Ready wins over a counter expiring in the same cycle.
        if (data_sram_ready) begin
          rdata_d = we_q ? '0 : lane_rdata;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          bus_err_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_wait         = (state_q == S_WAIT);
  assign data_sram_en    = in_wait;
  assign data_sram_wen   = in_wait ? lane_wen : '0;
  assign data_sram_addr  = in_wait ? {addr_q[MemAddrW-1:2], 2'b00} : '0;
  assign data_sram_wdata = in_wait ? lane_wdata : '0;

  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign bus_err    = bus_err_q;

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign addr_err = addr_err_q;
  assign badvaddr = badvaddr_q;
`else
  assign addr_err = 1'b0;
  assign badvaddr = '0;
  logic unused_align;
  assign unused_align = addr_err_q ^ (^badvaddr_q);
`endif

endmodule
